// File: rtl/ahb_interface.sv
// ahb_interface: AHB-Lite slave front end for a NONSEQ/SEQ transfer subset.
//
// - Each active transfer latches its address phase into a one-deep register.
//   On the following edge the data phase completes and produces a
//   wr_valid or rd_valid pulse.
// - HTRANS=BUSY is treated as illegal. Malformed SEQ bursts are flagged.
// - err_count counts all error pulses and saturates.
// - err_sticky holds the OR of all error pulses until err_clr.
// - Optional macro AHB_IF_STATS_EN adds the NONSEQ/SEQ counters nonseq_cnt
//   and seq_cnt.
module ahb_interface #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              err_clr,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              err_busy,
    output logic              err_seq,
    output logic              err_sticky,
    output logic [7:0]        err_count
`ifdef AHB_IF_STATS_EN
    ,
    output logic [15:0]       nonseq_cnt,
    output logic [15:0]       seq_cnt
`endif
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    // Tracks whether the previous sampled cycle was an active transfer.
    // A SEQ is legal only when it directly follows an active transfer.
    typedef enum logic {
        ST_NOACT = 1'b0,
        ST_ACT   = 1'b1
    } burst_state_e;

    burst_state_e      r_state;
    burst_state_e      w_state_next;
    logic [ADDR_W-1:0] r_prev_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic              r_ap_valid;
    logic              r_ap_write;
    logic [ADDR_W-1:0] r_ap_addr;
    logic              w_active;
    logic              w_busy;
    logic              w_seq_err;
    logic [8:0]        w_cnt_sum;

    assign w_active    = HTRANS[1];
    assign w_next_addr = r_prev_addr + ADDR_W'(1);

    // Burst tracker state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ST_NOACT;
            r_prev_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_active) begin
                r_prev_addr <= HADDR;
            end
        end
    end

    // Next burst state and error detection for the sampled HTRANS.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_seq_err    = 1'b0;
        case (htrans_e'(HTRANS))
            TR_IDLE: begin
                w_state_next = ST_NOACT;
            end
            TR_BUSY: begin
                w_state_next = ST_NOACT;
                w_busy       = 1'b1;
            end
            TR_NONSEQ: begin
                w_state_next = ST_ACT;
            end
            TR_SEQ: begin
                w_state_next = ST_ACT;
                w_seq_err    = (r_state != ST_ACT) || (HADDR != w_next_addr);
            end
            default: begin
                w_state_next = ST_NOACT;
            end
        endcase
    end

    // One-deep address-phase register. BUSY and IDLE latch nothing.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_ap_valid <= 1'b0;
            r_ap_write <= 1'b0;
            r_ap_addr  <= '0;
        end else begin
            r_ap_valid <= w_active;
            if (w_active) begin
                r_ap_write <= HWRITE;
                r_ap_addr  <= HADDR;
            end
        end
    end

    // Data phase completes one edge after the address phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
        end else begin
            wr_valid <= r_ap_valid && r_ap_write;
            rd_valid <= r_ap_valid && !r_ap_write;
            if (r_ap_valid && r_ap_write) begin
                wr_addr <= r_ap_addr;
                wr_data <= HWDATA;
            end
            if (r_ap_valid && !r_ap_write) begin
                rd_addr <= r_ap_addr;
            end
        end
    end

    assign w_cnt_sum = {1'b0, err_count} + 9'(w_busy) + 9'(w_seq_err);

    // Error pulses, saturating error count, and sticky flag.
    // When an error and err_clr coincide, the set takes priority.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_busy   <= 1'b0;
            err_seq    <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            err_busy  <= w_busy;
            err_seq   <= w_seq_err;
            err_count <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
            if (w_busy || w_seq_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

`ifdef AHB_IF_STATS_EN
    // Wrapping counters of sampled NONSEQ and SEQ transfers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            nonseq_cnt <= '0;
            seq_cnt    <= '0;
        end else begin
            if (HTRANS == TR_NONSEQ) begin
                nonseq_cnt <= nonseq_cnt + 16'd1;
            end
            if (HTRANS == TR_SEQ) begin
                seq_cnt <= seq_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ahb_interface.sv
// Directed testbench for ahb_interface (default build).
module tb_ahb_interface;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HWDATA;
    logic              err_clr;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              err_busy;
    logic              err_seq;
    logic              err_sticky;
    logic [7:0]        err_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ahb_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HADDR      (HADDR),
        .HWRITE     (HWRITE),
        .HTRANS     (HTRANS),
        .HWDATA     (HWDATA),
        .err_clr    (err_clr),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .err_busy   (err_busy),
        .err_seq    (err_seq),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a cycle's inputs, then advance past the next rising edge.
    task automatic step(input logic [1:0] tr, input logic wr,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        HTRANS = tr;
        HWRITE = wr;
        HADDR  = a;
        HWDATA = d;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET = 1'b1;
        HADDR = '0;
        HWRITE = 1'b0;
        HTRANS = 2'b00;
        HWDATA = '0;
        err_clr = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        HRESET = 1'b0;

        // IDLE with write-looking inputs captures nothing
        step(2'b00, 1'b1, 21'h10_0000, 8'hAA);
        step(2'b00, 1'b1, 21'h10_0000, 8'hAA);
        check("idle_wr_valid", 32'(wr_valid), 32'd0);
        check("idle_rd_valid", 32'(rd_valid), 32'd0);
        check("idle_wr_addr", 32'(wr_addr), 32'd0);
        check("idle_err", 32'(err_sticky), 32'd0);

        // Single NONSEQ write
        step(2'b10, 1'b1, 21'h10_0000, 8'h00);
        check("wr_addrph_valid", 32'(wr_valid), 32'd0);
        step(2'b00, 1'b0, 21'h00_0000, 8'hAA);
        check("wr_valid", 32'(wr_valid), 32'd1);
        check("wr_addr", 32'(wr_addr), 32'h10_0000);
        check("wr_data", 32'(wr_data), 32'hAA);
        step(2'b00, 1'b0, 21'h00_0000, 8'h55);
        check("wr_valid_pulse", 32'(wr_valid), 32'd0);
        check("wr_data_hold", 32'(wr_data), 32'hAA);

        // Single NONSEQ read
        step(2'b10, 1'b0, 21'h0F_0000, 8'h00);
        check("rd_addrph_valid", 32'(rd_valid), 32'd0);
        step(2'b00, 1'b0, 21'h00_0000, 8'h00);
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("rd_addr", 32'(rd_addr), 32'h0F_0000);
        step(2'b00, 1'b0, 21'h00_0000, 8'h00);
        check("rd_valid_pulse", 32'(rd_valid), 32'd0);

        // Back-to-back NONSEQ/SEQ writes pipeline
        step(2'b10, 1'b1, 21'h00_0010, 8'h00);
        step(2'b11, 1'b1, 21'h00_0011, 8'h11);
        check("pipe1_valid", 32'(wr_valid), 32'd1);
        check("pipe1_addr", 32'(wr_addr), 32'h10);
        check("pipe1_data", 32'(wr_data), 32'h11);
        check("pipe_no_seq_err", 32'(err_seq), 32'd0);
        step(2'b00, 1'b0, 21'h00_0000, 8'h22);
        check("pipe2_valid", 32'(wr_valid), 32'd1);
        check("pipe2_addr", 32'(wr_addr), 32'h11);
        check("pipe2_data", 32'(wr_data), 32'h22);

        // BUSY three times
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 1'b1, 21'h00_0040, 8'h00);
            check("busy_pulse", 32'(err_busy), 32'd1);
        end
        check("busy_count", 32'(err_count), 32'd3);
        check("busy_sticky", 32'(err_sticky), 32'd1);
        step(2'b00, 1'b0, 21'h00_0000, 8'h00);
        check("busy_end", 32'(err_busy), 32'd0);
        check("busy_no_wr", 32'(wr_valid), 32'd0);
        err_clr = 1'b1;
        step(2'b00, 1'b0, 21'h00_0000, 8'h00);
        err_clr = 1'b0;
        check("clr_sticky", 32'(err_sticky), 32'd0);
        check("clr_count", 32'(err_count), 32'd3);

        // Address wrap on SEQ, then SEQ after IDLE
        step(2'b10, 1'b0, 21'h1F_FFFF, 8'h00);
        step(2'b11, 1'b0, 21'h00_0000, 8'h00);
        check("wrap_no_err", 32'(err_seq), 32'd0);
        check("wrap_rd_addr0", 32'(rd_addr), 32'h1F_FFFF);
        step(2'b00, 1'b0, 21'h00_0000, 8'h00);
        check("wrap_rd_addr1", 32'(rd_addr), 32'h00_0000);
        step(2'b11, 1'b0, 21'h00_0001, 8'h00);
        check("seq_after_idle", 32'(err_seq), 32'd1);
        check("seq_after_idle_cnt", 32'(err_count), 32'd4);
        step(2'b00, 1'b0, 21'h00_0000, 8'h00);
        check("seq_err_pulse", 32'(err_seq), 32'd0);
        check("seq_err_xfer", 32'(rd_valid), 32'd1);
        check("seq_err_xfer_addr", 32'(rd_addr), 32'h1);

        // Set-wins on simultaneous clear, and SEQ address discontinuity
        err_clr = 1'b1;
        step(2'b00, 1'b0, 21'h00_0000, 8'h00);
        check("clr2_sticky", 32'(err_sticky), 32'd0);
        step(2'b11, 1'b0, 21'h00_0005, 8'h00);
        err_clr = 1'b0;
        check("set_wins", 32'(err_sticky), 32'd1);
        step(2'b10, 1'b0, 21'h00_0020, 8'h00);
        check("ns_no_err", 32'(err_seq), 32'd0);
        step(2'b11, 1'b0, 21'h00_0022, 8'h00);
        check("seq_skip_err", 32'(err_seq), 32'd1);
        check("seq_skip_cnt", 32'(err_count), 32'd6);
        step(2'b00, 1'b0, 21'h00_0000, 8'h00);

        // Reset between write address and data phase
        step(2'b10, 1'b1, 21'h10_0000, 8'h00);
        HRESET = 1'b1;
        #1;
        check("arst_wr_addr", 32'(wr_addr), 32'd0);
        check("arst_rd_addr", 32'(rd_addr), 32'd0);
        check("arst_count", 32'(err_count), 32'd0);
        step(2'b00, 1'b0, 21'h00_0000, 8'hAA);
        HRESET = 1'b0;
        step(2'b00, 1'b0, 21'h00_0000, 8'hAA);
        check("arst_no_wr", 32'(wr_valid), 32'd0);
        check("arst_no_wr_data", 32'(wr_data), 32'd0);
        step(2'b11, 1'b0, 21'h00_0001, 8'h00);
        check("seq_after_rst", 32'(err_seq), 32'd1);
        check("seq_after_rst_cnt", 32'(err_count), 32'd1);

        // Saturation of err_count
        for (int i = 0; i < 260; i++) begin
            step(2'b01, 1'b0, 21'h00_0000, 8'h00);
        end
        check("count_sat", 32'(err_count), 32'd255);
        step(2'b00, 1'b0, 21'h00_0000, 8'h00);
        check("count_sat_hold", 32'(err_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_interface.md
AHB_INTERFACE -- requirements
Module: ahb_interface

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, HADDR width.
REQ-002 SHALL have parameter DATA_W, default 8, HWDATA/wr_data width; byte-addressed, SEQ increment 1.
REQ-003 HCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 HRESET  in  1  asynchronous, active-high reset.
REQ-005 HADDR  in  ADDR_W  address-phase address.
REQ-006 HWRITE  in  1  1 = write, 0 = read, address phase.
REQ-007 HTRANS  in  2  00 IDLE, 01 BUSY (illegal in this subset), 10 NONSEQ, 11 SEQ.
REQ-008 HWDATA  in  DATA_W  write data, data phase.
REQ-009 err_clr  in  1  clears err_sticky.
REQ-010 wr_valid  out  1  one-cycle pulse, write data phase done.
REQ-011 wr_addr / wr_data  out  ADDR_W / DATA_W  captured write address and data.
REQ-012 rd_valid  out  1  one-cycle pulse, read data phase reached.
REQ-013 rd_addr  out  ADDR_W  captured read address.
REQ-014 err_busy  out  1  one-cycle pulse, illegal HTRANS=01 sampled.
REQ-015 err_seq  out  1  one-cycle pulse, SEQ protocol violation.
REQ-016 err_sticky  out  1  OR of all error pulses since reset/clear.
REQ-017 err_count  out  8  error event count, saturating.

Function
REQ-018 Signals SHALL be sampled at HCLK rising edge; active transfer = HTRANS 10 or 11.
REQ-019 IDLE SHALL capture nothing, regardless of HWRITE/HADDR/HWDATA.
REQ-020 Active transfer at edge N SHALL latch HADDR/HWRITE into a one-deep address-phase register.
REQ-021 At edge N+1, latched write SHALL load wr_data<=HWDATA, wr_addr<=latched addr, pulse wr_valid one cycle (visible after N+1).
REQ-022 At edge N+1, latched read SHALL load rd_addr, pulse rd_valid one cycle.
REQ-023 Back-to-back transfers SHALL pipeline: data phase of N overlaps address phase of N+1, no lost transfers.
REQ-024 wr_addr/wr_data/rd_addr SHALL hold value until next capture.
REQ-025 HTRANS=01 sampled SHALL pulse err_busy next cycle; no address phase latched.
REQ-026 SEQ after IDLE, BUSY or reset SHALL pulse err_seq; transfer still performed.
REQ-027 SEQ with HADDR != previous active address + 1 (mod 2^ADDR_W) SHALL pulse err_seq; 0x1F_FFFF -> 0x00_0000 legal.
REQ-028 err_busy and err_seq same cycle SHALL increment err_count by 2, saturating at 255.
REQ-029 err_sticky SHALL set on any error pulse; err_clr clears it; simultaneous set and clear -> set wins.
REQ-030 err_count SHALL be unaffected by err_clr.

Reset
REQ-031 HRESET SHALL immediately clear all outputs, the address-phase register and the previous-address tracker to 0.
REQ-032 Reset mid-operation SHALL discard any pending data phase; no wr_valid/rd_valid after release.
REQ-033 First SEQ after reset release SHALL be flagged per REQ-026.

Configuration
REQ-034 Macro AHB_IF_STATS_EN defined: SHALL add outputs nonseq_cnt and seq_cnt, 16 bits, wrapping, reset 0, +1 per sampled NONSEQ/SEQ.
REQ-035 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-036 IDLE, HADDR=0x10_0000, HWRITE=1, HWDATA=0xAA -> no wr_valid/rd_valid, no error.
REQ-037 NONSEQ write 0x10_0000, next cycle HWDATA=0xAA -> wr_valid one cycle, wr_addr=0x10_0000, wr_data=0xAA.
REQ-038 NONSEQ read 0x0F_0000 -> rd_valid one cycle later, rd_addr=0x0F_0000.
REQ-039 HTRANS=01 for 3 cycles -> err_busy pulses 3 times, err_count=3, err_sticky=1; err_clr -> err_sticky=0, err_count=3.
REQ-040 NONSEQ 0x1F_FFFF then SEQ 0x00_0000 -> no err_seq; IDLE then SEQ 0x00_0001 -> err_seq pulse.
REQ-041 HRESET asserted between write address and data phase -> outputs 0 immediately, no wr_valid afterwards.
